mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage RV32IM pipeline, between execute and write-back.
//  Accepts one instruction at a time from execute via valid/rdy and issues data-memory
//  load/store requests. Aligns and sign- or zero-extends load data.
//  Presents Rd results and exception status to write-back on the M2W valid/rdy handshake.
// PARAMETERS
//  XLEN        32   data/address width
//  DM_TIMEOUT  255  cycles to wait for dm_ack before a bus-timeout exception; 0 = never time out
// PORTS
//  clk_in          in   1     clock; all state updates on rising edge
//  reset_in        in   1     reset, asynchronous, active-low
//  cpu_halt        in   1     1 = accept no new instruction from execute
//  e2m_valid       in   1     execute has an instruction
//  e2m_rdy         out  1     this stage accepts the instruction this cycle
//  e2m_is_ld       in   1     instruction is a load
//  e2m_is_st       in   1     instruction is a store (never both is_ld and is_st)
//  e2m_size        in   2     00 byte, 01 half, 10 word, 11 treated as word
//  e2m_unsigned    in   1     LBU/LHU zero-extend
//  e2m_addr        in   XLEN  effective byte address
//  e2m_st_data     in   XLEN  store data (low bits significant)
//  e2m_rd_wr       in   1     instruction writes Rd
//  e2m_rd_addr     in   5     destination register
//  e2m_rd_data     in   XLEN  ALU result (used by non-loads)
//  dm_req          out  1     data-memory request
//  dm_we           out  1     1 = store, 0 = load
//  dm_be           out  4     byte enables
//  dm_addr         out  XLEN  word address ({e2m_addr[XLEN-1:2],2'b00})
//  dm_wdata        out  XLEN  lane-replicated store data
//  dm_ack          in   1     request complete; dm_rdata valid for loads
//  dm_rdata        in   XLEN  raw load word
//  m2w_valid       out  1     result held for write-back
//  m2w_rdy         in   1     write-back accepts result
//  m2w_rd_wr       out  1     write Rd
//  m2w_rd_addr     out  5     destination register
//  m2w_rd_data     out  XLEN  result data
//  m2w_exc         out  2     00 none, 01 misaligned load, 10 misaligned store, 11 bus timeout
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timeout counter 0. e2m_rdy=0 while reset_in=0.
//  FSM:
//   - IDLE: no instruction held.
//   - MEM: dm_req=1; dm_we/dm_be/dm_addr/dm_wdata stable until dm_ack.
//   - OUT: m2w_valid=1; m2w_* stable until m2w_rdy.
//  e2m_rdy = !cpu_halt & (IDLE | (OUT & m2w_rdy)). Accept = e2m_valid & e2m_rdy.
//  On accept:
//   - Aligned load/store -> MEM.
//   - Anything else -> OUT with m2w_rd_data = e2m_rd_data.
//   - OUT & m2w_rdy & no accept -> IDLE.
//  Misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
//   - Goes to OUT, no dm_req, exc=01 or 10, m2w_rd_wr=0.
//  MEM & dm_ack -> OUT:
//   - Load: m2w_rd_data = formatted dm_rdata.
//   - Store: m2w_rd_wr=0.
//  Counter increments each MEM cycle without ack. Reaching DM_TIMEOUT -> OUT, exc=11,
//  m2w_rd_wr=0, dm_req dropped.
//  Latency (accept edge = cycle 0):
//   - Non-mem/misaligned: m2w_valid in cycle 1.
//   - Mem: dm_req in cycle 1; m2w_valid the cycle after dm_ack.
//   - Back-to-back non-mem instructions: one per cycle.
//  Load formatting, lane k = addr[1:0]:
//   - LB/LBU: byte k.
//   - LH/LHU: halfword addr[1].
//   - Sign-extend unless e2m_unsigned.
//   - LW: whole word.
//  Store: dm_be = 0001<<k (byte), 0011<<k (half), 1111 (word).
//   dm_wdata = {4{b}} (byte), {2{h}} (half), or full word.
//  cpu_halt blocks new accepts only; in-flight MEM/OUT complete normally.
//  Async reset mid-MEM: dm_req drops immediately and the request is abandoned;
//  memory must tolerate the withdrawn request.
//  dm_ack outside MEM is ignored.
// TESTING
//  1. ADD rd=5 data=0x1234 accepted, m2w_rdy=1 -> m2w_valid next cycle, rd_data=0x1234, exc=00; 3 back-to-back, 1/cycle.
//  2. LB addr=0x103, dm_rdata=0x80FF_0000 after 2-cycle ack -> dm_addr=0x100, dm_be=0000 (load), rd_data=0xFFFFFF80; LBU -> 0x00000080.
//  3. SH addr=0x102 data=0xABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, m2w_rd_wr=0, exc=00.
//  4. LW addr=0x101 -> no dm_req, m2w_valid cycle 1, exc=01, rd_wr=0; SW addr=0x103 -> exc=10.
//  5. LW with no dm_ack, DM_TIMEOUT=4 -> dm_req high 4 cycles, then exc=11, dm_req=0.
//  6. m2w_rdy=0 for 3 cycles -> m2w_* stable, e2m_rdy=0; reset_in low during MEM -> dm_req=0, m2w_valid=0 immediately.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32IM memory stage: data-memory access, load alignment, write-back handoff
module mem_stage #(
    parameter int XLEN       = 32,
    parameter int DM_TIMEOUT = 255
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            cpu_halt,
    input  logic            e2m_valid,
    output logic            e2m_rdy,
    input  logic            e2m_is_ld,
    input  logic            e2m_is_st,
    input  logic [1:0]      e2m_size,
    input  logic            e2m_unsigned,
    input  logic [XLEN-1:0] e2m_addr,
    input  logic [XLEN-1:0] e2m_st_data,
    input  logic            e2m_rd_wr,
    input  logic [4:0]      e2m_rd_addr,
    input  logic [XLEN-1:0] e2m_rd_data,
    output logic            dm_req,
    output logic            dm_we,
    output logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            m2w_valid,
    input  logic            m2w_rdy,
    output logic            m2w_rd_wr,
    output logic [4:0]      m2w_rd_addr,
    output logic [XLEN-1:0] m2w_rd_data,
    output logic [1:0]      m2w_exc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam int CW = (DM_TIMEOUT < 2) ? 1 : $clog2(DM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DM_TIMEOUT - 1);

    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_MIS_LD = 2'b01;
    localparam logic [1:0] EXC_MIS_ST = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    logic [1:0]      state;
    logic [CW-1:0]   to_cnt;
    logic [1:0]      ld_size;
    logic [1:0]      ld_lane;
    logic            ld_uns;

    logic            accept;
    logic            is_mem;
    logic            misaligned;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;

    assign is_mem     = e2m_is_ld | e2m_is_st;
    assign misaligned = ((e2m_size == 2'b01) & e2m_addr[0]) | (e2m_size[1] & (|e2m_addr[1:0]));
    assign e2m_rdy    = reset_in & ~cpu_halt &
                        ((state == ST_IDLE) | ((state == ST_OUT) & m2w_rdy));
    assign accept     = e2m_valid & e2m_rdy;
    assign dm_req     = (state == ST_MEM);
    assign m2w_valid  = (state == ST_OUT);

    // Store lanes: narrow data is replicated so the memory picks it up via dm_be alone.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = e2m_st_data;
        case (e2m_size)
            2'b00: begin
                st_be    = 4'b0001 << e2m_addr[1:0];
                st_wdata = {(XLEN/8){e2m_st_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << e2m_addr[1:0];
                st_wdata = {(XLEN/16){e2m_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dm_rdata[{ld_lane, 3'b000} +: 8];
        ld_half = dm_rdata[{ld_lane[1], 4'b0000} +: 16];
        case (ld_size)
            2'b00:   ld_fmt = {{(XLEN-8){ld_byte[7] & ~ld_uns}}, ld_byte};
            2'b01:   ld_fmt = {{(XLEN-16){ld_half[15] & ~ld_uns}}, ld_half};
            default: ld_fmt = dm_rdata;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            ld_size     <= 2'b00;
            ld_lane     <= 2'b00;
            ld_uns      <= 1'b0;
            dm_we       <= 1'b0;
            dm_be       <= 4'b0000;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            m2w_rd_wr   <= 1'b0;
            m2w_rd_addr <= 5'd0;
            m2w_rd_data <= '0;
            m2w_exc     <= EXC_NONE;
        end else if (accept) begin
            to_cnt      <= '0;
            ld_size     <= e2m_size;
            ld_lane     <= e2m_addr[1:0];
            ld_uns      <= e2m_unsigned;
            m2w_rd_addr <= e2m_rd_addr;
            m2w_rd_data <= e2m_rd_data;
            if (is_mem && !misaligned) begin
                state     <= ST_MEM;
                dm_we     <= e2m_is_st;
                dm_be     <= e2m_is_st ? st_be : 4'b0000;
                dm_addr   <= {e2m_addr[XLEN-1:2], 2'b00};
                dm_wdata  <= e2m_is_st ? st_wdata : '0;
                m2w_rd_wr <= e2m_rd_wr & e2m_is_ld;
                m2w_exc   <= EXC_NONE;
            end else begin
                state     <= ST_OUT;
                m2w_rd_wr <= e2m_rd_wr & ~is_mem;
                m2w_exc   <= !is_mem ? EXC_NONE : (e2m_is_ld ? EXC_MIS_LD : EXC_MIS_ST);
            end
        end else begin
            case (state)
                ST_MEM: begin
                    if (dm_ack) begin
                        state <= ST_OUT;
                        if (!dm_we) m2w_rd_data <= ld_fmt;
                    end else if ((DM_TIMEOUT != 0) && (to_cnt == CNT_LAST)) begin
                        state     <= ST_OUT;
                        m2w_rd_wr <= 1'b0;
                        m2w_exc   <= EXC_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_OUT: if (m2w_rdy) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural reference model
module tb_mem_stage;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk_in = 1'b0;
    logic            reset_in = 1'b0;
    logic            cpu_halt = 1'b0;
    logic            e2m_valid = 1'b0;
    logic            e2m_rdy;
    logic            e2m_is_ld = 1'b0;
    logic            e2m_is_st = 1'b0;
    logic [1:0]      e2m_size = 2'b00;
    logic            e2m_unsigned = 1'b0;
    logic [XLEN-1:0] e2m_addr = '0;
    logic [XLEN-1:0] e2m_st_data = '0;
    logic            e2m_rd_wr = 1'b0;
    logic [4:0]      e2m_rd_addr = '0;
    logic [XLEN-1:0] e2m_rd_data = '0;
    logic            dm_req;
    logic            dm_we;
    logic [3:0]      dm_be;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_ack = 1'b0;
    logic [XLEN-1:0] dm_rdata = '0;
    logic            m2w_valid;
    logic            m2w_rdy = 1'b1;
    logic            m2w_rd_wr;
    logic [4:0]      m2w_rd_addr;
    logic [XLEN-1:0] m2w_rd_data;
    logic [1:0]      m2w_exc;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(XLEN), .DM_TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt),
        .e2m_valid(e2m_valid), .e2m_rdy(e2m_rdy), .e2m_is_ld(e2m_is_ld), .e2m_is_st(e2m_is_st),
        .e2m_size(e2m_size), .e2m_unsigned(e2m_unsigned), .e2m_addr(e2m_addr),
        .e2m_st_data(e2m_st_data), .e2m_rd_wr(e2m_rd_wr), .e2m_rd_addr(e2m_rd_addr),
        .e2m_rd_data(e2m_rd_data), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .m2w_valid(m2w_valid), .m2w_rdy(m2w_rdy), .m2w_rd_wr(m2w_rd_wr),
        .m2w_rd_addr(m2w_rd_addr), .m2w_rd_data(m2w_rd_data), .m2w_exc(m2w_exc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: what one instruction should do, from the ISA-level rules.
    function automatic void model(
        input  logic ld, input logic st, input logic [1:0] size, input logic uns,
        input  logic [31:0] addr, input logic [31:0] st_data, input logic rd_wr,
        input  logic [31:0] rd_data, input logic [31:0] rdata,
        output logic mem, output logic [3:0] be, output logic [31:0] wdata,
        output logic exp_wr, output logic [31:0] exp_data, output logic [1:0] exp_exc);
        int k;
        int nbytes;
        logic [31:0] v;
        logic [31:0] mask;
        k = int'(addr % 4);
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mem = (ld || st) && ((addr % nbytes) == 0);
        be = 4'b0000; wdata = 32'd0; exp_wr = rd_wr; exp_data = rd_data; exp_exc = 2'd0;
        if ((ld || st) && !mem) begin
            exp_wr = 1'b0;
            exp_exc = ld ? 2'd1 : 2'd2;
        end else if (st) begin
            be = 4'(((1 << nbytes) - 1) << k);
            if (nbytes == 1)      wdata = (st_data & 32'hFF) * 32'h0101_0101;
            else if (nbytes == 2) wdata = (st_data & 32'hFFFF) * 32'h0001_0001;
            else                  wdata = st_data;
            exp_wr = 1'b0;
        end else if (ld) begin
            v = rdata >> (8 * k);
            if (nbytes < 4) begin
                mask = (32'd1 << (8 * nbytes)) - 32'd1;
                v = v & mask;
                if (!uns && v[8*nbytes-1]) v = v | ~mask;
            end
            exp_data = v;
        end
    endfunction

    task automatic set_instr(input logic ld, input logic st, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                             input logic rw, input logic [4:0] ra, input logic [31:0] rdat);
        e2m_is_ld = ld; e2m_is_st = st; e2m_size = size; e2m_unsigned = uns;
        e2m_addr = addr; e2m_st_data = sd; e2m_rd_wr = rw; e2m_rd_addr = ra; e2m_rd_data = rdat;
    endtask

    // Raise e2m_valid and return just after the accepting clock edge.
    task automatic accept_one();
        bit ok;
        ok = 0;
        e2m_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (e2m_rdy === 1'b1) ok = 1;
            @(posedge clk_in);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept: e2m_rdy=%b never asserted, required 1", e2m_rdy);
        end
    endtask

    task automatic run_txn(input string name, input logic ld, input logic st,
                           input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] sd, input logic rw, input logic [4:0] ra,
                           input logic [31:0] rdat, input logic [31:0] rdata, input int ack_wait);
        logic mem, ewr;
        logic [3:0] ebe;
        logic [31:0] ewd, edata;
        logic [1:0] eexc;
        model(ld, st, size, uns, addr, sd, rw, rdat, rdata, mem, ebe, ewd, ewr, edata, eexc);
        @(negedge clk_in);
        m2w_rdy = 1'b1;
        set_instr(ld, st, size, uns, addr, sd, rw, ra, rdat);
        accept_one();
        @(negedge clk_in);
        e2m_valid = 1'b0;
        if (mem) begin
            checks++;
            if (dm_req !== 1'b1 || m2w_valid !== 1'b0 || dm_we !== st || dm_be !== ebe ||
                dm_addr !== {addr[31:2], 2'b00} || (st && dm_wdata !== ewd)) begin
                errors++;
                $display("FAIL %s dm_req: req=%b we=%b be=%b addr=%h wdata=%h, required req=1 we=%b be=%b addr=%h wdata=%h",
                         name, dm_req, dm_we, dm_be, dm_addr, dm_wdata, st, ebe,
                         {addr[31:2], 2'b00}, ewd);
            end
            for (int i = 0; i < ack_wait; i++) @(negedge clk_in);
            checks++;
            if (dm_req !== 1'b1) begin
                errors++;
                $display("FAIL %s dm_req hold: got %b, required 1", name, dm_req);
            end
            dm_ack = 1'b1;
            dm_rdata = rdata;
            @(negedge clk_in);
            dm_ack = 1'b0;
            dm_rdata = $urandom;
        end else begin
            checks++;
            if (dm_req !== 1'b0) begin
                errors++;
                $display("FAIL %s no dm_req: got %b, required 0", name, dm_req);
            end
        end
        checks++;
        if (m2w_valid !== 1'b1 || m2w_rd_wr !== ewr || m2w_rd_addr !== ra || m2w_exc !== eexc ||
            (!st && eexc == 2'd0 && m2w_rd_data !== edata)) begin
            errors++;
            $display("FAIL %s m2w: valid=%b wr=%b rd=%0d data=%h exc=%b, required valid=1 wr=%b rd=%0d data=%h exc=%b",
                     name, m2w_valid, m2w_rd_wr, m2w_rd_addr, m2w_rd_data, m2w_exc,
                     ewr, ra, edata, eexc);
        end
    endtask

    task automatic test_reset();
        e2m_valid = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        checks++;
        if (e2m_rdy !== 1'b0 || dm_req !== 1'b0 || m2w_valid !== 1'b0 || dm_we !== 1'b0 ||
            dm_be !== 4'b0 || dm_addr !== 32'd0 || dm_wdata !== 32'd0 || m2w_rd_wr !== 1'b0 ||
            m2w_rd_addr !== 5'd0 || m2w_rd_data !== 32'd0 || m2w_exc !== 2'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b req=%b valid=%b be=%b addr=%h data=%h exc=%b, required all 0",
                     e2m_rdy, dm_req, m2w_valid, dm_be, dm_addr, m2w_rd_data, m2w_exc);
        end
        e2m_valid = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in);
        m2w_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 5'(5 + i), 32'h1234 + i);
            e2m_valid = 1'b1;
            #1;
            checks++;
            if (e2m_rdy !== 1'b1 || (i > 0 && (m2w_valid !== 1'b1 || m2w_rd_data !== 32'h1234 + i - 1 ||
                m2w_rd_addr !== 5'(4 + i) || m2w_exc !== 2'd0))) begin
                errors++;
                $display("FAIL b2b[%0d]: rdy=%b valid=%b data=%h, required rdy=1 valid=%0d data=%h",
                         i, e2m_rdy, m2w_valid, m2w_rd_data, i > 0, 32'h1234 + i - 1);
            end
            @(negedge clk_in);
        end
        e2m_valid = 1'b0;
        checks++;
        if (m2w_valid !== 1'b1 || m2w_rd_data !== 32'h1236 || m2w_rd_wr !== 1'b1 || m2w_exc !== 2'd0) begin
            errors++;
            $display("FAIL b2b last: valid=%b data=%h, required valid=1 data=00001236", m2w_valid, m2w_rd_data);
        end
    endtask

    task automatic test_directed();
        run_txn("ADD", 1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 5'd5, 32'h1234, 32'd0, 0);
        run_txn("LB", 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 1'b1, 5'd6, 32'd0, 32'h80FF_0000, 1);
        run_txn("LBU", 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 1'b1, 5'd6, 32'd0, 32'h80FF_0000, 1);
        run_txn("LH", 1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 1'b1, 5'd7, 32'd0, 32'h9ABC_1234, 0);
        run_txn("SH", 1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD, 1'b1, 5'd8, 32'd0, 32'd0, 1);
        run_txn("SB", 1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h5A, 1'b0, 5'd0, 32'd0, 32'd0, 0);
        run_txn("LWmis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 1'b1, 5'd9, 32'd0, 32'd0, 0);
        run_txn("SWmis", 1'b0, 1'b1, 2'd2, 1'b0, 32'h103, 32'h1, 1'b0, 5'd0, 32'd0, 32'd0, 0);
        run_txn("LHmis", 1'b1, 1'b0, 2'd1, 1'b0, 32'h201, 32'd0, 1'b1, 5'd3, 32'd0, 32'd0, 0);
    endtask

    task automatic test_timeout();
        @(negedge clk_in);
        m2w_rdy = 1'b1;
        set_instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1, 5'd10, 32'd0);
        accept_one();
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk_in);
            e2m_valid = 1'b0;
            checks++;
            if (dm_req !== 1'b1 || m2w_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout wait[%0d]: req=%b valid=%b, required req=1 valid=0", c, dm_req, m2w_valid);
            end
        end
        @(negedge clk_in);
        checks++;
        if (dm_req !== 1'b0 || m2w_valid !== 1'b1 || m2w_exc !== 2'b11 || m2w_rd_wr !== 1'b0) begin
            errors++;
            $display("FAIL timeout: req=%b valid=%b exc=%b wr=%b, required req=0 valid=1 exc=11 wr=0",
                     dm_req, m2w_valid, m2w_exc, m2w_rd_wr);
        end
    endtask

    task automatic test_stall();
        @(negedge clk_in);
        m2w_rdy = 1'b0;
        set_instr(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE_0001);
        accept_one();
        @(negedge clk_in);
        set_instr(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hCAFE_0002);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (m2w_valid !== 1'b1 || m2w_rd_addr !== 5'd7 || m2w_rd_data !== 32'hCAFE_0001 ||
                m2w_rd_wr !== 1'b1 || e2m_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b rd=%0d data=%h rdy=%b, required valid=1 rd=7 data=cafe0001 rdy=0",
                         c, m2w_valid, m2w_rd_addr, m2w_rd_data, e2m_rdy);
            end
            @(negedge clk_in);
        end
        m2w_rdy = 1'b1;
        #1;
        checks++;
        if (e2m_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall release: rdy=%b, required 1", e2m_rdy);
        end
        @(negedge clk_in);
        e2m_valid = 1'b0;
        checks++;
        if (m2w_valid !== 1'b1 || m2w_rd_addr !== 5'd8 || m2w_rd_data !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL stall next: valid=%b rd=%0d data=%h, required valid=1 rd=8 data=cafe0002",
                     m2w_valid, m2w_rd_addr, m2w_rd_data);
        end
    endtask

    task automatic test_halt();
        @(negedge clk_in);
        cpu_halt = 1'b1;
        set_instr(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 32'h77);
        e2m_valid = 1'b1;
        dm_ack = 1'b1;
        #1;
        checks++;
        if (e2m_rdy !== 1'b0) begin
            errors++;
            $display("FAIL halt rdy: got %b, required 0", e2m_rdy);
        end
        repeat (2) @(negedge clk_in);
        checks++;
        if (m2w_valid !== 1'b0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL halt idle: valid=%b req=%b, required 0 0", m2w_valid, dm_req);
        end
        e2m_valid = 1'b0;
        dm_ack = 1'b0;
        cpu_halt = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk_in);
        m2w_rdy = 1'b1;
        set_instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1'b1, 5'd11, 32'd0);
        accept_one();
        @(negedge clk_in);
        checks++;
        if (dm_req !== 1'b1) begin
            errors++;
            $display("FAIL pre-reset req: got %b, required 1", dm_req);
        end
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if (dm_req !== 1'b0 || m2w_valid !== 1'b0 || e2m_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset mid-MEM: req=%b valid=%b rdy=%b, required 0 0 0", dm_req, m2w_valid, e2m_rdy);
        end
        e2m_valid = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    task automatic test_random();
        logic ld, st, uns;
        logic [1:0] size;
        logic [31:0] addr;
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ld = (kind == 1);
            st = (kind == 2);
            size = 2'($urandom_range(0, 3));
            uns = 1'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            run_txn("rand", ld, st, size, uns, addr, $urandom, 1'($urandom), 5'($urandom),
                    $urandom, $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_timeout();
        test_stall();
        test_halt();
        test_reset_mid_mem();
        test_random();
        @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
